pixel_clock_monitor: RTL and testbench

Checks the divided pixel clock that drives the SVGA timing logic. All logic runs on SYSTEM_CLOCK. The block measures the pixel clock frequency against SYSTEM_CLOCK and detects a stalled pixel clock. It produces three outputs:
- a one-cycle pixel strobe for downstream logic;
- a lock flag;
- an active-high reset to the VGA timing generator, held until the pixel clock has been stable for several measurement windows.

---
 rtl/pixel_clock_monitor.sv | 142 ++++++++++++++
 tb/tb_pixel_clock_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_clock_monitor.sv
// Measures the divided pixel clock against SYSTEM_CLOCK, detects stalls and
// holds the VGA timing generator in reset until the pixel clock is locked.
module pixel_clock_monitor #(
  parameter int DIV          = 4,
  parameter int WINDOW       = 256,
  parameter int TOL          = 1,
  parameter int LOCK_WINDOWS = 4,
  parameter int STALL        = 16,
  parameter int CNT_W        = $clog2(WINDOW + 1)
) (
  input  logic             SYSTEM_CLOCK,
  input  logic             reset_n,
  input  logic             pixel_clock,
  input  logic             fault_clr,
  output logic             pixel_enable,
  output logic             locked,
  output logic             pixel_reset,
  output logic             fault,
  output logic [CNT_W-1:0] edge_count
);

  localparam int EXPECT   = WINDOW / DIV;
  localparam int LO_BOUND = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
  localparam int HI_BOUND = EXPECT + TOL;
  localparam int WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int STALL_W  = $clog2(STALL + 1);
  localparam int RUN_W    = $clog2(LOCK_WINDOWS + 1);

  localparam logic [CNT_W-1:0]   LO_C       = CNT_W'(LO_BOUND);
  localparam logic [CNT_W-1:0]   HI_C       = CNT_W'(HI_BOUND);
  localparam logic [WIN_W-1:0]   WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL);
  localparam logic [STALL_W-1:0] STALL_PRE  = STALL_W'(STALL - 1);
  localparam logic [RUN_W-1:0]   RUN_TARGET = RUN_W'(LOCK_WINDOWS);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic               pix_q;
  logic               rise;
  logic [WIN_W-1:0]   win_cnt;
  logic [CNT_W-1:0]   acc;
  logic [CNT_W-1:0]   measured;
  logic [STALL_W-1:0] stall_cnt;
  logic               win_end;
  logic               win_good;
  logic               stall_evt;
  logic               bad_evt;
  logic [0:0]         state;
  logic [0:0]         state_nxt;
  logic [RUN_W-1:0]   good_run;
  logic [RUN_W-1:0]   good_run_nxt;
  logic               fault_set;
  logic               next_locked;

  assign rise      = pixel_clock & ~pix_q;
  assign win_end   = (win_cnt == WIN_LAST);
  // The rise landing in the final window cycle belongs to that window.
  assign measured  = acc + CNT_W'(rise);
  assign win_good  = (measured >= LO_C) && (measured <= HI_C);
  assign stall_evt = !rise && (stall_cnt == STALL_PRE);
  // A stall always spoils the window, even if the edge count looked fine.
  assign bad_evt   = stall_evt || (win_end && !win_good);

  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    fault_set    = 1'b0;
    case (state)
      ST_UNLOCKED: begin
        if (bad_evt) begin
          good_run_nxt = '0;
        end else if (win_end) begin
          if (good_run + RUN_W'(1) == RUN_TARGET) begin
            state_nxt    = ST_LOCKED;
            good_run_nxt = '0;
          end else begin
            good_run_nxt = good_run + RUN_W'(1);
          end
        end
      end
      default: begin
        if (bad_evt) begin
          state_nxt    = ST_UNLOCKED;
          good_run_nxt = '0;
          fault_set    = 1'b1;
        end
      end
    endcase
  end

  assign next_locked = (state_nxt == ST_LOCKED);

  always_ff @(posedge SYSTEM_CLOCK) begin
    if (!reset_n) begin
      pix_q        <= 1'b0;
      pixel_enable <= 1'b0;
      win_cnt      <= '0;
      acc          <= '0;
      edge_count   <= '0;
      stall_cnt    <= '0;
      state        <= ST_UNLOCKED;
      good_run     <= '0;
      locked       <= 1'b0;
      pixel_reset  <= 1'b1;
      fault        <= 1'b0;
    end else begin
      pix_q        <= pixel_clock;
      pixel_enable <= rise;

      if (win_end) begin
        win_cnt    <= '0;
        acc        <= '0;
        edge_count <= measured;
      end else begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (rise) begin
          acc <= acc + CNT_W'(1);
        end
      end

      if (rise) begin
        stall_cnt <= '0;
      end else if (stall_cnt != STALL_MAX) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end

      state       <= state_nxt;
      good_run    <= good_run_nxt;
      locked      <= next_locked;
      pixel_reset <= ~next_locked;

      // Losing lock outranks a clear arriving in the same cycle.
      if (fault_set) begin
        fault <= 1'b1;
      end else if (fault_clr) begin
        fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_clock_monitor.sv
// Directed bench for pixel_clock_monitor with default parameters; cyc holds
// the index of the cycle whose outputs are visible after each step.
module tb_pixel_clock_monitor;

  logic       SYSTEM_CLOCK;
  logic       reset_n;
  logic       pixel_clock;
  logic       fault_clr;
  logic       pixel_enable;
  logic       locked;
  logic       pixel_reset;
  logic       fault;
  logic [8:0] edge_count;

  int cyc;
  int checks;
  int errors;

  pixel_clock_monitor dut (
    .SYSTEM_CLOCK (SYSTEM_CLOCK),
    .reset_n      (reset_n),
    .pixel_clock  (pixel_clock),
    .fault_clr    (fault_clr),
    .pixel_enable (pixel_enable),
    .locked       (locked),
    .pixel_reset  (pixel_reset),
    .fault        (fault),
    .edge_count   (edge_count)
  );

  initial SYSTEM_CLOCK = 1'b0;
  always #5 SYSTEM_CLOCK = ~SYSTEM_CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One SYSTEM_CLOCK cycle with the given pixel_clock level.
  task automatic step(input logic pc);
    pixel_clock = pc;
    @(posedge SYSTEM_CLOCK);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input logic pc);
    reset_n = 1'b0;
    repeat (3) step(pc);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  // Nominal clock: low on cycles 0,1 and high on 2,3 (mod 4).
  task automatic nom_to(input int t);
    while (cyc < t) step((cyc % 4) >= 2);
  endtask

  task automatic low_to(input int t);
    while (cyc < t) step(1'b0);
  endtask

  task automatic pulse2_to(input int t);
    while (cyc < t) step((cyc % 2) == 1);
  endtask

  task automatic third_to(input int t);
    while (cyc < t) step((cyc % 3) == 0);
  endtask

  // One full window of 64 four-cycle periods; delta>0 doubles the first
  // delta periods (+1 edge each), delta<0 blanks the first -delta periods.
  task automatic run_window(input int delta);
    for (int p = 0; p < 64; p++) begin
      if (p < delta) begin
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
      end else if (p < -delta) begin
        repeat (4) step(1'b0);
      end else begin
        step(1'b0); step(1'b0); step(1'b1); step(1'b1);
      end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    pixel_clock = 1'b0;
    fault_clr   = 1'b0;
    cyc         = 0;
    checks      = 0;
    errors      = 0;

    // Nominal lock
    do_reset(1'b0);
    check("rst_pe", pixel_enable, 0);
    check("rst_locked", locked, 0);
    check("rst_preset", pixel_reset, 1);
    check("rst_fault", fault, 0);
    check("rst_ec", edge_count, 0);
    nom_to(3);    check("nom_pe_hi", pixel_enable, 1);
    nom_to(4);    check("nom_pe_lo", pixel_enable, 0);
    nom_to(7);    check("nom_pe_hi2", pixel_enable, 1);
    nom_to(255);  check("nom_ec_pre", edge_count, 0);
    nom_to(256);  check("nom_ec_w0", edge_count, 64);
                  check("nom_unlocked_w0", locked, 0);
    nom_to(1023); check("nom_locked_pre", locked, 0);
                  check("nom_preset_pre", pixel_reset, 1);
    nom_to(1024); check("nom_locked", locked, 1);
                  check("nom_preset", pixel_reset, 0);
                  check("nom_fault", fault, 0);
                  check("nom_ec_w3", edge_count, 64);

    // Stall while locked: last rise on cycle 1098, stall event on 1114
    nom_to(1099);
    low_to(1114); check("stall_locked_pre", locked, 1);
    low_to(1115); check("stall_locked", locked, 0);
                  check("stall_preset", pixel_reset, 1);
                  check("stall_fault", fault, 1);
    nom_to(1280); check("stall_ec", edge_count, 61);
    nom_to(2303); check("relock_pre", locked, 0);
    nom_to(2304); check("relock", locked, 1);
                  check("relock_fault_sticky", fault, 1);
    fault_clr = 1'b1;
    nom_to(2305);
    fault_clr = 1'b0;
                  check("fault_clr", fault, 0);
                  check("fault_clr_locked", locked, 1);

    // 64 edges with the last one on 2543: stall event lands on window end 2559
    nom_to(2528);
    pulse2_to(2544);
    low_to(2559); check("coin_locked_pre", locked, 1);
                  check("coin_fault_pre", fault, 0);
    fault_clr = 1'b1;
    low_to(2560);
    fault_clr = 1'b0;
                  check("coin_locked", locked, 0);
                  check("coin_fault", fault, 1);
                  check("coin_ec", edge_count, 64);
                  check("coin_preset", pixel_reset, 1);

    // Relock, then reset mid-window
    nom_to(3583); check("relock2_pre", locked, 0);
    nom_to(3584); check("relock2", locked, 1);
                  check("relock2_fault", fault, 1);
    nom_to(3700);
    reset_n = 1'b0;
    nom_to(3701);
                  check("mid_rst_locked", locked, 0);
                  check("mid_rst_preset", pixel_reset, 1);
                  check("mid_rst_ec", edge_count, 0);
                  check("mid_rst_fault", fault, 0);
                  check("mid_rst_pe", pixel_enable, 0);
    reset_n = 1'b1;
    cyc = 0;
    nom_to(256);  check("post_rst_ec", edge_count, 64);
    nom_to(1023); check("post_rst_locked_pre", locked, 0);
    nom_to(1024); check("post_rst_locked", locked, 1);

    // Tolerance edges: 64, 64, 66, 63, 65, 64, 64
    do_reset(1'b0);
    run_window(0);
    run_window(0);
    run_window(2);  check("tol_ec66", edge_count, 66);
    run_window(-1); check("tol_ec63", edge_count, 63);
                    check("tol_unlocked_w3", locked, 0);
    run_window(1);  check("tol_ec65", edge_count, 65);
                    check("tol_unlocked_w4", locked, 0);
    run_window(0);  check("tol_unlocked_w5", locked, 0);
    run_window(0);  check("tol_locked_w6", locked, 1);
                    check("tol_preset_w6", pixel_reset, 0);

    // Wrong frequency: period 3, pixel_clock high at reset release
    do_reset(1'b1);
    check("wf_rst_pe", pixel_enable, 0);
    third_to(1);    check("wf_pe_cycle0", pixel_enable, 1);
    third_to(256);  check("wf_ec_w0", edge_count, 86);
    third_to(512);  check("wf_ec_w1", edge_count, 85);
    third_to(1280); check("wf_ec_w4", edge_count, 85);
                    check("wf_locked", locked, 0);
                    check("wf_preset", pixel_reset, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
